// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   RV32I integer register file for the single-cycle core. It holds
//   2**ADDR_WIDTH entries of DATA_WIDTH bits. x0 has no storage and always
//   reads zero. There are two independent combinational read ports that feed
//   the ALU operands, and one write port that commits on the rising edge of
//   clk. An optional same-cycle bypass lets a read see the write-back value
//   while that value is still in flight.
//
// Parameters:
//   DATA_WIDTH   - width of each entry and of all data ports
//   ADDR_WIDTH   - register index width (2**ADDR_WIDTH entries)
//   SP_RESET     - reset value of x2 (stack pointer)
//   GP_RESET     - reset value of x3 (global pointer)
//   WRITE_BYPASS - 1: a read of the entry being written returns Write_Data_i
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high reset
//   Reg_Write_i       in   write enable for the current cycle
//   Write_Register_i  in   destination index (rd)
//   Read_Register_1_i in   source index rs1
//   Read_Register_2_i in   source index rs2
//   Write_Data_i      in   write-back value
//   Read_Data_1_o     out  contents of rs1 (ALU operand A)
//   Read_Data_2_o     out  contents of rs2 (ALU operand B / store data)
// -----------------------------------------------------------------------------
module register_file #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 5,
  parameter logic [DATA_WIDTH-1:0] SP_RESET     = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET     = 32'h1000_8000,
  parameter int                    WRITE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

  localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

  // Storage starts at index 1: x0 is hard-wired and never gets a flop.
  logic [DATA_WIDTH-1:0] entries [1:NUM_ENTRIES-1];

  // A write commits only when enabled, out of reset, and not aimed at x0.
  logic write_active;

  assign write_active = Reg_Write_i && !reset && (Write_Register_i != '0);

  // The loop bound limits the indices to those that exist, so in a small
  // configuration x2 and x3 simply never match.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
    if (idx == 2) begin
      return SP_RESET;
    end else if (idx == 3) begin
      return GP_RESET;
    end else begin
      return '0;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_ENTRIES; i++) begin
        entries[i] <= reset_value(i);
      end
    end else if (write_active) begin
      entries[Write_Register_i] <= Write_Data_i;
    end
  end

  // One read port. Index 0 short-circuits to zero before any array access.
  // When bypass is enabled, a matching in-flight write wins over stored data.
  // write_active already excludes x0 and reset, so bypass never applies there.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] value;
    if (idx == '0) begin
      value = '0;
    end else begin
      value = entries[idx];
    end
    if ((WRITE_BYPASS != 0) && write_active && (idx == Write_Register_i)) begin
      value = Write_Data_i;
    end
    return value;
  endfunction

  always_comb begin
    Read_Data_1_o = read_port(Read_Register_1_i);
  end

  always_comb begin
    Read_Data_2_o = read_port(Read_Register_2_i);
  end

`ifndef SYNTHESIS
  // The file assumes clean control inputs outside of reset. An unknown
  // enable or destination would silently corrupt state, so it is flagged here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({Reg_Write_i, Write_Register_i}))
        else $error("register_file: unknown write enable or index out of reset");
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int          DW = 32;
  localparam int          AW = 5;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [AW-1:0] wa, ra1, ra2;
  logic [DW-1:0] wd;
  logic [DW-1:0] nb_rd1, nb_rd2, bp_rd1, bp_rd2;

  int compared   = 0;
  int mismatched = 0;

  // Reference contents of x0..x31, updated once per clock edge.
  logic [DW-1:0] model [32];

  always #5 clk = ~clk;

  register_file #(.WRITE_BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Write_Data_i(wd),
    .Read_Data_1_o(nb_rd1), .Read_Data_2_o(nb_rd2)
  );

  register_file #(.WRITE_BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Write_Data_i(wd),
    .Read_Data_1_o(bp_rd1), .Read_Data_2_o(bp_rd2)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // What a port should show right now, given the stored model and the
  // inputs currently being driven.
  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] idx, input bit bypass);
    if (idx == 0) return '0;
    if (bypass && !reset && we && wa == idx) return wd;
    return model[idx];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_nb1"}, nb_rd1, expect_read(ra1, 0));
    check({tag, "_nb2"}, nb_rd2, expect_read(ra2, 0));
    check({tag, "_bp1"}, bp_rd1, expect_read(ra1, 1));
    check({tag, "_bp2"}, bp_rd2, expect_read(ra2, 1));
  endtask

  // Advance one edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      foreach (model[i]) model[i] = '0;
      model[2] = SP;
      model[3] = GP;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    reset = 1'b1; we = 1'b0; wa = '0; ra1 = '0; ra2 = '0; wd = '0;

    // Reset and sweep.
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(31 - i);
      #1;
      check("rst_sweep1", nb_rd1, (i == 2) ? SP : (i == 3) ? GP : 32'h0);
      check("rst_sweep2", bp_rd2, (31 - i == 2) ? SP : (31 - i == 3) ? GP : 32'h0);
      check_all("rst_sweep");
    end

    // Basic write/read.
    we = 1'b1; wa = 5'd5;  wd = 32'hDEAD_BEEF; tick();
    wa = 5'd31; wd = 32'h0000_0001; tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd31;
    for (int i = 0; i < 10; i++) begin
      wd = $urandom;
      #1;
      check("basic_rs1", nb_rd1, 32'hDEAD_BEEF);
      check("basic_rs2", bp_rd2, 32'h0000_0001);
      check_all("basic");
      tick();
    end

    // x0 protection.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    check("x0_inflight_bp1", bp_rd1, 32'h0);
    check("x0_inflight_bp2", bp_rd2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("x0_after_nb", nb_rd1, 32'h0);
    check("x0_after_bp", bp_rd2, 32'h0);

    // Read-during-write on x7.
    we = 1'b1; wa = 5'd7; wd = 32'h1111_1111; tick();
    wd = 32'h2222_2222; ra1 = 5'd7; ra2 = 5'd7;
    #1;
    check("rdw_before_nb", nb_rd1, 32'h1111_1111);
    check("rdw_before_bp", bp_rd1, 32'h2222_2222);
    tick();
    we = 1'b0;
    #1;
    check("rdw_after_nb", nb_rd2, 32'h2222_2222);
    check("rdw_after_bp", bp_rd2, 32'h2222_2222);

    // Reset priority over a same-cycle write to x2.
    reset = 1'b1; we = 1'b1; wa = 5'd2; wd = 32'h0000_1234; ra1 = 5'd2; ra2 = 5'd7;
    #1;
    check("rstpri_bypass_off", bp_rd1, SP);
    tick();
    check("rstpri_nb", nb_rd1, SP);
    check("rstpri_x7_lost", nb_rd2, 32'h0);
    reset = 1'b0;
    tick();
    we = 1'b0;
    #1;
    check("postrst_write_nb", nb_rd1, 32'h0000_1234);
    check("postrst_write_bp", bp_rd1, 32'h0000_1234);

    // Write-enable gating.
    we = 1'b0; wa = 5'd9; wd = 32'hCAFE_F00D; ra1 = 5'd9; ra2 = 5'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_nb", nb_rd1, 32'h0);
      check("gate_bp", bp_rd2, 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      we    = $urandom_range(0, 2) != 0;
      wa    = AW'($urandom);
      ra1   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      ra2   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      wd    = $urandom;
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit RV32I integer register file for the single-cycle core.
- Sits directly upstream of the ALU: Read_Data_1_o drives ALU operand A; Read_Data_2_o drives operand B, or the store-data path when the ALU source mux selects the immediate.
- Write-back value (ALU result, load data or PC+4) returns on Write_Data_i and commits on the rising clock edge.
- Reads are combinational so decode, execute and write-back complete in one cycle.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- SP_RESET, 32'h7FFF_EFFC, reset value of x2 (stack pointer).
- GP_RESET, 32'h1000_8000, reset value of x3 (global pointer).
- WRITE_BYPASS, 0, when 1 a same-cycle read of the register being written returns Write_Data_i.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- Reg_Write_i  input  1  write enable for the current cycle.
- Write_Register_i  input  ADDR_WIDTH  destination register index (rd).
- Read_Register_1_i  input  ADDR_WIDTH  source index rs1.
- Read_Register_2_i  input  ADDR_WIDTH  source index rs2.
- Write_Data_i  input  DATA_WIDTH  write-back value.
- Read_Data_1_o  output  DATA_WIDTH  contents of rs1; feeds ALU A_i.
- Read_Data_2_o  output  DATA_WIDTH  contents of rs2; feeds ALU B_i / store data.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Storage: entries x1..x31 are flops. x0 has no storage and always reads 32'h0.
- Reset, on an edge with reset=1:
  - x2 <= SP_RESET; x3 <= GP_RESET; all other entries <= 0.
  - Reset has priority over any write in the same cycle; that write is discarded.
- Write, on an edge with reset=0, Reg_Write_i=1 and Write_Register_i != 0: entry[Write_Register_i] <= Write_Data_i.
  - Writes to x0 are ignored.
  - Reg_Write_i=0 leaves every entry unchanged.
- Reads:
  - Purely combinational, zero latency: Read_Data_n_o = entry[Read_Register_n_i], or 0 when the index is 0.
  - Both ports are independent and may address the same register.
- Output values after reset: the outputs are not registered. After the reset edge they show the reset value of the addressed entry: 0 for most indices, SP_RESET for x2, GP_RESET for x3.
- Read-during-write, same index in the same cycle:
  - WRITE_BYPASS=0: output shows the old value until the edge and the new value immediately after it.
  - WRITE_BYPASS=1: output shows Write_Data_i while Reg_Write_i=1 and reset=0.
  - In both modes, bypass never applies to x0, and bypass is suppressed while reset=1.
- Reset mid-operation:
  - Asserting reset in any cycle overrides a pending write at that edge.
  - Contents written before the reset edge are lost.
  - The first write after reset deasserts commits normally at the next edge.
- Width rules:
  - Indices are unsigned. Data are stored and returned bit-exact, with no sign or zero extension.
  - ADDR_WIDTH=5 is the only configuration the core uses. Other values must still elaborate, with x2/x3 reset values applied only when those indices exist.
- Undefined inputs: X on Reg_Write_i or Write_Register_i while reset=0 is a verification error, flagged by an assertion; the file is not required to tolerate it.

Test Plan:
- Reset: hold reset=1 for one edge; sweep both read ports over 0..31 -> x2=32'h7FFF_EFFC, x3=32'h1000_8000, all others 32'h0.
- Basic write/read: write x5=32'hDEAD_BEEF, then x31=32'h0000_0001 on consecutive edges with Reg_Write_i=1; read rs1=5, rs2=31 -> 32'hDEAD_BEEF and 32'h0000_0001. Reads are stable with Reg_Write_i=0 and Write_Data_i toggling randomly for 10 cycles.
- x0 protection: write x0=32'hFFFF_FFFF with Reg_Write_i=1 -> both ports read 32'h0 for index 0, including with WRITE_BYPASS=1 while the write is in flight.
- Read-during-write on x7, old value 32'h1111_1111, writing 32'h2222_2222:
  - WRITE_BYPASS=0: 32'h1111_1111 before the edge, 32'h2222_2222 after it.
  - WRITE_BYPASS=1: 32'h2222_2222 before the edge.
- Reset priority: write x2=32'h0000_1234 in the same cycle as reset=1 -> x2 reads 32'h7FFF_EFFC after the edge. In the next cycle (reset=0), the same write yields 32'h0000_1234.
- Write-enable gating: Reg_Write_i=0 with Write_Register_i=9, Write_Data_i=32'hCAFE_F00D for 5 edges -> x9 stays 32'h0. Random 1000-cycle write/read sequence matches the scoreboard model.
